// File: rtl/nbout_buffer.sv
// NBout scratchpad: row capture from NFU-2/NFU-3, partial-sum readback and valid/ready drain to eDRAM.
// Optional NBOUT_BYPASS_EN: same-cycle write-to-read/drain forwarding.
module nbout_buffer #(
  parameter int N      = 16,
  parameter int Tn     = 16,
  parameter int DEPTH  = 64,
  parameter int ADDR_W = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_wr_en,
  input  logic [ADDR_W-1:0] i_wr_addr,
  input  logic [N*Tn-1:0]   i_wr_data,
  input  logic              i_wr_final,
  input  logic              i_rd_en,
  input  logic [ADDR_W-1:0] i_rd_addr,
  output logic [N*Tn-1:0]   o_rd_data,
  output logic              o_rd_valid,
  input  logic              i_drain_start,
  input  logic [ADDR_W-1:0] i_drain_base,
  input  logic [ADDR_W:0]   i_drain_count,
  output logic [N*Tn-1:0]   o_drain_data,
  output logic              o_drain_valid,
  input  logic              i_drain_ready,
  output logic              o_drain_busy,
  output logic              o_drain_done,
  output logic [ADDR_W:0]   o_final_cnt
);

  // state | meaning
  // IDLE  | waiting for a drain start; partial-sum reads served
  // DRAIN | streaming rows to eDRAM; reads ignored
  // DONE  | one-cycle completion pulse
  typedef enum logic [1:0] {IDLE, DRAIN, DONE} state_t;

  localparam int W = N * Tn;

  state_t            state, state_nxt;
  logic [W-1:0]      mem [DEPTH];
  logic [DEPTH-1:0]  flags;
  logic [ADDR_W-1:0] ptr;
  logic [ADDR_W:0]   remaining;
  logic              fetch, finish, rd_acc, wr_hit_ptr;
  logic              set_inc, wr_dec, clr_dec;
  logic [W-1:0]      rd_word, drain_word;

  assign rd_acc     = i_rd_en && (state != DRAIN);
  assign fetch      = (state == DRAIN) && (!o_drain_valid || i_drain_ready) && (remaining != '0);
  assign finish     = (state == DRAIN) && o_drain_valid && i_drain_ready && (remaining == '0);
  assign wr_hit_ptr = i_wr_en && (i_wr_addr == ptr);

`ifdef NBOUT_BYPASS_EN
  assign rd_word    = (i_wr_en && (i_wr_addr == i_rd_addr)) ? i_wr_data : mem[i_rd_addr];
  assign drain_word = wr_hit_ptr ? i_wr_data : mem[ptr];
`else
  assign rd_word    = mem[i_rd_addr];
  assign drain_word = mem[ptr];
`endif

  // A write landing on the row being fetched owns that row's flag.
  assign set_inc = i_wr_en && i_wr_final && !flags[i_wr_addr];
  assign wr_dec  = i_wr_en && !i_wr_final && flags[i_wr_addr];
  assign clr_dec = fetch && flags[ptr] && !wr_hit_ptr;

  assign o_drain_busy = (state == DRAIN);
  assign o_drain_done = (state == DONE);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (i_drain_start) state_nxt = (i_drain_count == '0) ? DONE : DRAIN;
      DRAIN:   if (finish) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (i_wr_en) mem[i_wr_addr] <= i_wr_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      flags         <= '0;
      o_final_cnt   <= '0;
      ptr           <= '0;
      remaining     <= '0;
      o_rd_data     <= '0;
      o_rd_valid    <= 1'b0;
      o_drain_data  <= '0;
      o_drain_valid <= 1'b0;
    end else begin
      state       <= state_nxt;
      o_rd_valid  <= rd_acc;
      if (rd_acc) o_rd_data <= rd_word;

      if (state == IDLE && i_drain_start) begin
        ptr       <= i_drain_base;
        remaining <= i_drain_count;
      end

      if (fetch) begin
        o_drain_data  <= drain_word;
        o_drain_valid <= 1'b1;
        flags[ptr]    <= 1'b0;
        ptr           <= ptr + 1'b1;
        remaining     <= remaining - 1'b1;
      end else if (finish) begin
        o_drain_valid <= 1'b0;
      end

      if (i_wr_en) flags[i_wr_addr] <= i_wr_final;

      o_final_cnt <= o_final_cnt + {{ADDR_W{1'b0}}, set_inc}
                                 - {{ADDR_W{1'b0}}, wr_dec}
                                 - {{ADDR_W{1'b0}}, clr_dec};
    end
  end

endmodule

// File: tb/tb_nbout_buffer.sv
// Scoreboard bench for nbout_buffer: directed stimulus pushes expected rows, a negedge monitor checks them.
module tb_nbout_buffer;
  localparam int N = 16, TN = 16, AW = 6, W = N * TN;

  logic          clk = 0;
  logic          rst = 1;
  logic          wr_en = 0, wr_final = 0, rd_en = 0, drain_start = 0, drain_ready = 1;
  logic [AW-1:0] wr_addr = '0, rd_addr = '0, drain_base = '0;
  logic [W-1:0]  wr_data = '0;
  logic [AW:0]   drain_count = '0;
  logic [W-1:0]  rd_data, drain_data;
  logic          rd_valid, drain_valid, drain_busy, drain_done;
  logic [AW:0]   final_cnt;

  int tests = 0, fails = 0;
  logic [W-1:0] rd_q[$];
  logic [W-1:0] dr_q[$];
  int  xfers = 0, done_cnt = 0, rd_seen = 0, dvalid_seen = 0;
  logic         stalled = 0;
  logic [W-1:0] held;

  nbout_buffer dut (
    .clk(clk), .rst(rst),
    .i_wr_en(wr_en), .i_wr_addr(wr_addr), .i_wr_data(wr_data), .i_wr_final(wr_final),
    .i_rd_en(rd_en), .i_rd_addr(rd_addr), .o_rd_data(rd_data), .o_rd_valid(rd_valid),
    .i_drain_start(drain_start), .i_drain_base(drain_base), .i_drain_count(drain_count),
    .o_drain_data(drain_data), .o_drain_valid(drain_valid), .i_drain_ready(drain_ready),
    .o_drain_busy(drain_busy), .o_drain_done(drain_done), .o_final_cnt(final_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [W-1:0] rowv(input int r);
    logic [15:0] b;
    b = 16'(r * 257) ^ 16'hA500;
    return {TN{b}};
  endfunction

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: compares every presented read/drain row against the scoreboard queues.
  always @(negedge clk) begin
    if (!rst) begin
      if (drain_done) done_cnt++;
      if (drain_valid) dvalid_seen++;
      if (stalled) begin
        chk("stall_valid", W'(drain_valid), W'(1));
        chk("stall_data", drain_data, held);
      end
      stalled = drain_valid && !drain_ready;
      held    = drain_data;
      if (rd_valid) begin
        rd_seen++;
        if (rd_q.size() == 0) chk("rd_unexpected", W'(1), W'(0));
        else chk("rd_data", rd_data, rd_q.pop_front());
      end
      if (drain_valid && drain_ready) begin
        xfers++;
        if (dr_q.size() == 0) chk("drain_unexpected", W'(1), W'(0));
        else chk("drain_data", drain_data, dr_q.pop_front());
      end
    end else stalled = 0;
  end

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  task automatic wr(input int a, input logic [W-1:0] d, input logic f);
    wr_en = 1; wr_addr = AW'(a); wr_data = d; wr_final = f;
    cyc();
    wr_en = 0; wr_final = 0;
  endtask

  task automatic start_drain(input int base, input int cnt);
    drain_start = 1; drain_base = AW'(base); drain_count = (AW+1)'(cnt);
    for (int i = 0; i < cnt; i++) dr_q.push_back(rowv((base + i) % 64));
    cyc();
    drain_start = 0;
  endtask

  logic pat [5] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
  logic [W-1:0] exp7;
  int n, d0, x0;

  initial begin
    repeat (2) cyc();
    chk("rst_rd_valid", W'(rd_valid), W'(0));
    chk("rst_drain_valid", W'(drain_valid), W'(0));
    chk("rst_busy", W'(drain_busy), W'(0));
    chk("rst_done", W'(drain_done), W'(0));
    chk("rst_final_cnt", W'(final_cnt), W'(0));
    chk("rst_drain_data", drain_data, '0);
    rst = 0;
    cyc();

    // basic write then read, 1-cycle latency
    wr(5, {TN{16'h0001}}, 0);
    rd_en = 1; rd_addr = 5; rd_q.push_back({TN{16'h0001}});
    cyc();
    rd_en = 0;
    chk("rd_latency_valid", W'(rd_valid), W'(1));
    cyc();

    // same-cycle read/write collision
    wr(7, {TN{16'h1111}}, 0);
`ifdef NBOUT_BYPASS_EN
    exp7 = {TN{16'hAAAA}};
`else
    exp7 = {TN{16'h1111}};
`endif
    wr_en = 1; wr_addr = 7; wr_data = {TN{16'hAAAA}};
    rd_en = 1; rd_addr = 7; rd_q.push_back(exp7);
    cyc();
    wr_en = 0;
    rd_q.push_back({TN{16'hAAAA}});
    cyc();
    rd_en = 0;
    cyc();

    // final flags and counting
    wr(62, rowv(62), 1); wr(63, rowv(63), 1); wr(0, rowv(0), 1); wr(1, rowv(1), 1);
    chk("final_cnt_4", W'(final_cnt), W'(4));
    wr(62, rowv(62), 1);
    chk("final_cnt_reflag", W'(final_cnt), W'(4));
    wr(10, rowv(10), 1);
    chk("final_cnt_5", W'(final_cnt), W'(5));
    wr(10, rowv(10), 0);
    chk("final_cnt_unflag", W'(final_cnt), W'(4));

    // wrap-around drain, ready high
    d0 = done_cnt;
    start_drain(62, 4);
    chk("busy_after_start", W'(drain_busy), W'(1));
    n = 0;
    while (!drain_done && n < 40) begin cyc(); n++; end
    chk("wrap_done_cycles", W'(n), W'(5));
    cyc();
    chk("wrap_final_cnt", W'(final_cnt), W'(0));
    chk("wrap_busy", W'(drain_busy), W'(0));
    chk("wrap_q_empty", W'(dr_q.size()), W'(0));
    chk("wrap_done_pulses", W'(done_cnt - d0), W'(1));

    // stalled drain, reads ignored while draining
    wr(2, rowv(2), 0);
    x0 = xfers; rd_seen = 0;
    start_drain(0, 3);
    n = 0;
    while (!drain_done && n < 40) begin
      drain_ready = (n < 5) ? pat[n] : 1'b1;
      rd_en = (n < 3); rd_addr = 3;
      cyc(); n++;
      chk("rd_valid_in_drain", W'(rd_valid), W'(0));
    end
    rd_en = 0; drain_ready = 1;
    chk("stall_done_seen", W'(drain_done), W'(1));
    cyc();
    chk("stall_xfers", W'(xfers - x0), W'(3));
    chk("stall_q_empty", W'(dr_q.size()), W'(0));
    chk("stall_rd_seen", W'(rd_seen), W'(0));

    // zero-count drain
    dvalid_seen = 0;
    start_drain(20, 0);
    chk("zero_done", W'(drain_done), W'(1));
    chk("zero_busy", W'(drain_busy), W'(0));
    cyc();
    chk("zero_done_off", W'(drain_done), W'(0));
    cyc();
    chk("zero_no_valid", W'(dvalid_seen), W'(0));

    // reset during an 8-row drain
    for (int r = 8; r < 16; r++) wr(r, rowv(r), 1);
    chk("final_cnt_8", W'(final_cnt), W'(8));
    d0 = done_cnt; x0 = xfers;
    start_drain(8, 8);
    n = 0;
    while (xfers - x0 < 2 && n < 40) begin @(negedge clk); #1; n++; end
    chk("second_xfer_seen", W'(xfers - x0), W'(2));
    rst = 1;
    @(posedge clk); #1;
    rst = 0;
    dr_q.delete();
    @(negedge clk);
    chk("rst_mid_busy", W'(drain_busy), W'(0));
    chk("rst_mid_valid", W'(drain_valid), W'(0));
    chk("rst_mid_final_cnt", W'(final_cnt), W'(0));
    repeat (3) cyc();
    chk("rst_mid_no_done", W'(done_cnt - d0), W'(0));
    chk("rd_q_empty", W'(rd_q.size()), W'(0));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1);
  end
endmodule
